// File: rtl/pipeline_ctrl.sv
// Purpose: hazard/sequencing controller for the 5-stage pipeline (load-use, MEM-stage branch redirect, dmem wait with timeout fault).
// Latency: hazard responses are combinational (same cycle); FSM state and counters update on the next rising edge.
// Backpressure: dmem_ready low freezes PC, IF/ID and EX/MEM; after MEM_TIMEOUT busy cycles the pipeline freezes until rst.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_register_rd,
  input  logic             ex_mem_branch,
  input  logic             zero_flag_ex_mem,
  input  logic [31:0]      ex_mem_next_address_branch,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Last wait count before the fault; wait_cnt counts busy cycles already completed.
  localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic mem_busy;
  logic branch_taken;
  logic load_use;

  assign mem_busy     = (ex_mem_memread | ex_mem_memwrite) & ~dmem_ready;
  assign branch_taken = ex_mem_branch & zero_flag_ex_mem;
  assign load_use     = id_ex_memread & (id_ex_register_rd != 5'd0) &
                        ((id_ex_register_rd == if_id_rs1) | (id_ex_register_rd == if_id_rs2));

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: the busy cycle spent in RUN is counted on entry to WAIT,
  // so the fault lands on the edge ending the MEM_TIMEOUT-th consecutive busy cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          if (MEM_TIMEOUT <= 1) begin
            state_d = ST_FAULT;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 8'd1;
          end
        end
      end
      ST_WAIT: begin
        if (!mem_busy) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode in priority order: rst, FAULT, mem_busy, branch_taken, load_use.
  always_comb begin
    pc_write     = 1'b1;
    pc_src       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state_q == ST_FAULT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (mem_busy) begin
      // ID/EX holds through its enable, which the datapath ties to ex_mem_write.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (branch_taken) begin
      // The ID instruction is squashed, so any coincident load-use is moot.
      pc_src       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  assign pc_target    = ex_mem_next_address_branch;
  assign mem_fault    = (state_q == ST_FAULT);
  assign stall_cycles = stall_q;

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl with a short timeout and narrow stall counter.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns after it.
// Expected values come from constants and a cycle-level model of the hazard rules.
module tb_pipeline_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;

  // {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, ex_mem_flush, mem_fault}
  localparam logic [7:0] C_RST   = 8'b0001_1010;
  localparam logic [7:0] C_IDLE  = 8'b1010_0100;
  localparam logic [7:0] C_LU    = 8'b0000_1100;
  localparam logic [7:0] C_BR    = 8'b1111_1110;
  localparam logic [7:0] C_BUSY  = 8'b0000_0000;
  localparam logic [7:0] C_FAULT = 8'b0000_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    if_id_rs1, if_id_rs2, id_ex_register_rd;
  logic          id_ex_memread, ex_mem_branch, zero_flag_ex_mem;
  logic [31:0]   ex_mem_next_address_branch;
  logic          ex_mem_memread, ex_mem_memwrite, dmem_ready;
  logic          pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush;
  logic          ex_mem_write, ex_mem_flush, mem_fault;
  logic [31:0]   pc_target;
  logic [CW-1:0] stall_cycles;
  logic [7:0]    obs_ctrl;

  int errors = 0;
  int checks = 0;

  // Model state: consecutive busy edges, fault flag, stall count.
  int         m_cnt;
  bit         m_fault;
  int         m_stall;
  bit         m_busy;
  logic [7:0] exp_ctrl;
  logic [31:0] exp_tgt;
  int         exp_stall;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_register_rd(id_ex_register_rd),
    .ex_mem_branch(ex_mem_branch), .zero_flag_ex_mem(zero_flag_ex_mem),
    .ex_mem_next_address_branch(ex_mem_next_address_branch),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .pc_target(pc_target),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
    .ex_mem_flush(ex_mem_flush), .mem_fault(mem_fault),
    .stall_cycles(stall_cycles)
  );

  assign obs_ctrl = {pc_write, pc_src, if_id_write, if_id_flush,
                     id_ex_flush, ex_mem_write, ex_mem_flush, mem_fault};

  // Expected outputs for the current inputs from the priority table.
  function automatic void model_eval();
    bit br, lu;
    m_busy = (ex_mem_memread || ex_mem_memwrite) && !dmem_ready;
    br = ex_mem_branch && zero_flag_ex_mem;
    lu = id_ex_memread && (id_ex_register_rd != 0) &&
         ((id_ex_register_rd == if_id_rs1) || (id_ex_register_rd == if_id_rs2));
    exp_tgt   = ex_mem_next_address_branch;
    exp_stall = rst ? 0 : m_stall;
    if (rst)          exp_ctrl = C_RST;
    else if (m_fault) exp_ctrl = C_FAULT;
    else if (m_busy)  exp_ctrl = C_BUSY;
    else if (br)      exp_ctrl = C_BR;
    else if (lu)      exp_ctrl = C_LU;
    else              exp_ctrl = C_IDLE;
  endfunction

  // Model state advance at a rising edge.
  function automatic void model_update();
    if (rst) begin
      m_cnt = 0; m_fault = 0; m_stall = 0;
    end else begin
      if (!exp_ctrl[7] && m_stall < SAT) m_stall++;
      if (!m_fault) begin
        if (m_busy) begin
          m_cnt++;
          if (m_cnt >= TMO) m_fault = 1;
        end else begin
          m_cnt = 0;
        end
      end
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_register_rd = 0; id_ex_memread = 0;
    ex_mem_branch = 0; zero_flag_ex_mem = 0; ex_mem_next_address_branch = 0;
    ex_mem_memread = 0; ex_mem_memwrite = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    #2;
    checks++;
    if (obs_ctrl !== C_RST) begin errors++; $display("FAIL reset_ctrl got=%b want=%b", obs_ctrl, C_RST); end
    checks++;
    if (stall_cycles !== 3'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall_cycles); end
    tick(); tick();
    rst = 0;
    #2;
    checks++;
    if (obs_ctrl !== C_IDLE) begin errors++; $display("FAIL idle_ctrl got=%b want=%b", obs_ctrl, C_IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    id_ex_memread = 1; id_ex_register_rd = 5; if_id_rs2 = 5; if_id_rs1 = 1;
    #2;
    checks++;
    if (obs_ctrl !== C_LU) begin errors++; $display("FAIL lu_ctrl got=%b want=%b", obs_ctrl, C_LU); end
    tick();
    clear_inputs();
    #2;
    checks++;
    if (stall_cycles !== 3'd1) begin errors++; $display("FAIL lu_stall got=%0d want=1", stall_cycles); end
    checks++;
    if (obs_ctrl !== C_IDLE) begin errors++; $display("FAIL lu_release got=%b want=%b", obs_ctrl, C_IDLE); end
    id_ex_memread = 1; id_ex_register_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    #2;
    checks++;
    if (obs_ctrl !== C_IDLE) begin errors++; $display("FAIL lu_rd0_ctrl got=%b want=%b", obs_ctrl, C_IDLE); end
    tick();
    #2;
    checks++;
    if (stall_cycles !== 3'd1) begin errors++; $display("FAIL lu_rd0_stall got=%0d want=1", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_branch = 1; zero_flag_ex_mem = 0; ex_mem_next_address_branch = 32'h0000_0040;
    #2;
    checks++;
    if (obs_ctrl !== C_IDLE) begin errors++; $display("FAIL br_not_taken got=%b want=%b", obs_ctrl, C_IDLE); end
    zero_flag_ex_mem = 1;
    #1;
    checks++;
    if (obs_ctrl !== C_BR) begin errors++; $display("FAIL br_ctrl got=%b want=%b", obs_ctrl, C_BR); end
    checks++;
    if (pc_target !== 32'h0000_0040) begin errors++; $display("FAIL br_target got=%h want=00000040", pc_target); end
    id_ex_memread = 1; id_ex_register_rd = 7; if_id_rs1 = 7;
    #1;
    checks++;
    if (obs_ctrl !== C_BR) begin errors++; $display("FAIL br_over_lu got=%b want=%b", obs_ctrl, C_BR); end
    tick();
    clear_inputs();
    #2;
    checks++;
    if (stall_cycles !== 3'd0) begin errors++; $display("FAIL br_stall got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    ex_mem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (obs_ctrl !== C_BUSY) begin errors++; $display("FAIL wait_ctrl[%0d] got=%b want=%b", i, obs_ctrl, C_BUSY); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++;
    if (obs_ctrl !== C_IDLE) begin errors++; $display("FAIL wait_release got=%b want=%b", obs_ctrl, C_IDLE); end
    tick();
    clear_inputs();
    #2;
    checks++;
    if (stall_cycles !== 3'd3) begin errors++; $display("FAIL wait_stall got=%0d want=3", stall_cycles); end
    // A second 3-cycle store wait must not accumulate towards the timeout.
    ex_mem_memwrite = 1; dmem_ready = 0;
    tick(); tick(); tick();
    dmem_ready = 1;
    #2;
    checks++;
    if (obs_ctrl !== C_IDLE) begin errors++; $display("FAIL wait2_release got=%b want=%b", obs_ctrl, C_IDLE); end
    tick();
    clear_inputs();
    #2;
    checks++;
    if (stall_cycles !== 3'd6) begin errors++; $display("FAIL wait2_stall got=%0d want=6", stall_cycles); end
  endtask

  task automatic test_wait_branch();
    do_reset();
    ex_mem_memread = 1; dmem_ready = 0;
    ex_mem_branch = 1; zero_flag_ex_mem = 1; ex_mem_next_address_branch = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (obs_ctrl !== C_BUSY) begin errors++; $display("FAIL wbr_hold[%0d] got=%b want=%b", i, obs_ctrl, C_BUSY); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++;
    if (obs_ctrl !== C_BR) begin errors++; $display("FAIL wbr_redirect got=%b want=%b", obs_ctrl, C_BR); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    ex_mem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < TMO; i++) begin
      #2;
      checks++;
      if (obs_ctrl !== C_BUSY) begin errors++; $display("FAIL tmo_pre[%0d] got=%b want=%b", i, obs_ctrl, C_BUSY); end
      tick();
    end
    #2;
    checks++;
    if (obs_ctrl !== C_FAULT) begin errors++; $display("FAIL tmo_fault got=%b want=%b", obs_ctrl, C_FAULT); end
    dmem_ready = 1; ex_mem_branch = 1; zero_flag_ex_mem = 1;
    tick();
    #2;
    checks++;
    if (obs_ctrl !== C_FAULT) begin errors++; $display("FAIL tmo_sticky got=%b want=%b", obs_ctrl, C_FAULT); end
    checks++;
    if (stall_cycles !== 3'd5) begin errors++; $display("FAIL tmo_stall got=%0d want=5", stall_cycles); end
    rst = 1;
    #1;
    checks++;
    if (obs_ctrl !== C_RST) begin errors++; $display("FAIL tmo_rst_ctrl got=%b want=%b", obs_ctrl, C_RST); end
    checks++;
    if (stall_cycles !== 3'd0) begin errors++; $display("FAIL tmo_rst_stall got=%0d want=0", stall_cycles); end
    tick();
    rst = 0;
    #2;
    checks++;
    if (obs_ctrl !== C_BR) begin errors++; $display("FAIL tmo_recover got=%b want=%b", obs_ctrl, C_BR); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    id_ex_memread = 1; id_ex_register_rd = 3; if_id_rs1 = 3;
    for (int i = 1; i <= 10; i++) begin
      tick();
      #2;
      checks++;
      if (stall_cycles !== CW'((i < SAT) ? i : SAT)) begin
        errors++; $display("FAIL sat[%0d] got=%0d want=%0d", i, stall_cycles, (i < SAT) ? i : SAT);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 29) == 0);
      if_id_rs1 = 5'($urandom_range(0, 3));
      if_id_rs2 = 5'($urandom_range(0, 3));
      id_ex_register_rd = 5'($urandom_range(0, 3));
      id_ex_memread = $urandom_range(0, 1) == 1;
      ex_mem_branch = $urandom_range(0, 2) == 0;
      zero_flag_ex_mem = $urandom_range(0, 1) == 1;
      ex_mem_next_address_branch = $urandom;
      ex_mem_memread = $urandom_range(0, 3) == 0;
      ex_mem_memwrite = $urandom_range(0, 3) == 0;
      dmem_ready = $urandom_range(0, 1) == 1;
      #2;
      model_eval();
      checks++;
      if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL rnd_ctrl[%0d] got=%b want=%b", n, obs_ctrl, exp_ctrl); end
      checks++;
      if (pc_target !== exp_tgt) begin errors++; $display("FAIL rnd_target[%0d] got=%h want=%h", n, pc_target, exp_tgt); end
      checks++;
      if (stall_cycles !== CW'(exp_stall)) begin errors++; $display("FAIL rnd_stall[%0d] got=%0d want=%0d", n, stall_cycles, exp_stall); end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    m_cnt = 0; m_fault = 0; m_stall = 0; m_busy = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_wait_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
